// File: rtl/jtvigil_pkg.sv
// Shared types for the Vigilante ROM arbiter: FSM states, requester ids
// and the default SDRAM base offset of each requester.
package jtvigil_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_ACK = 2'd1,
      ST_WAIT_RDY = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      ID_SCR1 = 2'd0,
      ID_SCR2 = 2'd1,
      ID_OBJ  = 2'd2
   } req_id_t;

   localparam int          NREQ             = 3;
   localparam logic [21:0] SCR1_OFFSET_DEF  = 22'h000000;
   localparam logic [21:0] SCR2_OFFSET_DEF  = 22'h008000;
   localparam logic [21:0] OBJ_OFFSET_DEF   = 22'h010000;

   // Service order wraps scr1 -> scr2 -> obj -> scr1
   function automatic req_id_t next_id(input req_id_t id);
      case (id)
         ID_SCR1: return ID_SCR2;
         ID_SCR2: return ID_OBJ;
         default: return ID_SCR1;
      endcase
   endfunction

endpackage

// File: rtl/jtvigil_romarb_entry.sv
// One-word read cache owned by a single requester: tag, valid bit, data,
// and the combinational hit compare against the presented address.
module jtvigil_romarb_entry #(
   parameter int AW = 18
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cs,
   input  logic [AW-1:0] addr,
   input  logic          fill,
   input  logic [AW-1:0] fill_tag,
   input  logic [31:0]   fill_data,
   output logic [31:0]   data,
   output logic          ok
);

   logic [AW-1:0] tag;
   logic          valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag   <= '0;
         valid <= 1'b0;
         data  <= '0;
      end else if (fill) begin
         tag   <= fill_tag;
         valid <= 1'b1;
         data  <= fill_data;
      end
   end

   assign ok = cs & valid & (tag == addr);

endmodule

// File: rtl/jtvigil_romarb.sv
// Three-requester SDRAM ROM arbiter with a one-word cache per requester.
// Define JTVIGIL_ROMARB_RR_EN for round-robin grants; default is fixed
// priority scr1 > scr2 > obj.
module jtvigil_romarb
   import jtvigil_pkg::*;
#(
   parameter int            AW          = 18,
   parameter int            SW          = 22,
   parameter logic [SW-1:0] SCR1_OFFSET = SW'(SCR1_OFFSET_DEF),
   parameter logic [SW-1:0] SCR2_OFFSET = SW'(SCR2_OFFSET_DEF),
   parameter logic [SW-1:0] OBJ_OFFSET  = SW'(OBJ_OFFSET_DEF)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          scr1_cs,
   input  logic          scr2_cs,
   input  logic          obj_cs,
   input  logic [AW-1:0] scr1_addr,
   input  logic [AW-1:0] scr2_addr,
   input  logic [AW-1:0] obj_addr,
   output logic [31:0]   scr1_data,
   output logic [31:0]   scr2_data,
   output logic [31:0]   obj_data,
   output logic          scr1_ok,
   output logic          scr2_ok,
   output logic          obj_ok,
   output logic [SW-1:0] sdram_addr,
   output logic          sdram_req,
   input  logic          sdram_ack,
   input  logic          sdram_rdy,
   input  logic [31:0]   sdram_dout
);

   logic [NREQ-1:0]           cs_v, ok_v, pend, fill_v;
   logic [NREQ-1:0][AW-1:0]   addr_v;
   logic [NREQ-1:0][31:0]     data_v;
   logic [NREQ-1:0][SW-1:0]   off_v;

   state_t        st, st_nx;
   req_id_t       sel_id, cur_id;
   logic [AW-1:0] cur_addr;
   logic [SW-1:0] sel_addr;
   logic          grant, fill;

   assign cs_v   = {obj_cs, scr2_cs, scr1_cs};
   assign addr_v = {obj_addr, scr2_addr, scr1_addr};
   assign off_v  = {OBJ_OFFSET, SCR2_OFFSET, SCR1_OFFSET};
   assign pend   = cs_v & ~ok_v;

   assign {obj_ok, scr2_ok, scr1_ok}       = ok_v;
   assign {obj_data, scr2_data, scr1_data} = data_v;

   generate
      for (genvar i = 0; i < NREQ; i++) begin : g_ent
         assign fill_v[i] = fill && (cur_id == req_id_t'(i));
         jtvigil_romarb_entry #(.AW(AW)) u_ent (
            .clk       (clk),
            .rst_n     (rst_n),
            .cs        (cs_v[i]),
            .addr      (addr_v[i]),
            .fill      (fill_v[i]),
            .fill_tag  (cur_addr),
            .fill_data (sdram_dout),
            .data      (data_v[i]),
            .ok        (ok_v[i])
         );
      end
   endgenerate

`ifdef JTVIGIL_ROMARB_RR_EN
   req_id_t last_id;

   // Search begins just after the most recently granted requester
   always_comb begin
      req_id_t idx;
      logic    found;
      sel_id = ID_SCR1;
      found  = 1'b0;
      idx    = next_id(last_id);
      for (int k = 0; k < NREQ; k++) begin
         if (!found && pend[idx]) begin
            sel_id = idx;
            found  = 1'b1;
         end
         idx = next_id(idx);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     last_id <= ID_OBJ;
      else if (grant) last_id <= sel_id;
   end
`else
   always_comb begin
      sel_id = ID_OBJ;
      if      (pend[ID_SCR1]) sel_id = ID_SCR1;
      else if (pend[ID_SCR2]) sel_id = ID_SCR2;
   end
`endif

   assign sel_addr = SW'(addr_v[sel_id]) + off_v[sel_id];

   always_comb begin
      st_nx = st;
      grant = 1'b0;
      fill  = 1'b0;
      case (st)
         ST_IDLE: begin
            if (|pend) begin
               grant = 1'b1;
               st_nx = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            // ack and rdy together complete the whole access in one step
            if (sdram_ack) begin
               if (sdram_rdy) begin
                  fill  = 1'b1;
                  st_nx = ST_IDLE;
               end else begin
                  st_nx = ST_WAIT_RDY;
               end
            end
         end
         ST_WAIT_RDY: begin
            if (sdram_rdy) begin
               fill  = 1'b1;
               st_nx = ST_IDLE;
            end
         end
         default: st_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= ST_IDLE;
      else        st <= st_nx;
   end

   // The captured address, not the live one, tags the fill
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sdram_req  <= 1'b0;
         sdram_addr <= '0;
         cur_id     <= ID_SCR1;
         cur_addr   <= '0;
      end else if (grant) begin
         sdram_req  <= 1'b1;
         sdram_addr <= sel_addr;
         cur_id     <= sel_id;
         cur_addr   <= addr_v[sel_id];
      end else if (st == ST_WAIT_ACK && sdram_ack) begin
         sdram_req  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_jtvigil_romarb.sv
// Randomized and directed bench for jtvigil_romarb against a transaction-level
// model of the caches and the single outstanding SDRAM read.
module tb_jtvigil_romarb;

   localparam int            AW = 18;
   localparam int            SW = 22;
   localparam logic [SW-1:0] O1 = 22'h000000;
   localparam logic [SW-1:0] O2 = 22'h008000;
   localparam logic [SW-1:0] O3 = 22'h3C0001;

   logic          clk, rst_n;
   logic [2:0]    cs;
   logic [AW-1:0] a [3];
   logic          ack, rdy;
   logic [31:0]   dout;

   logic [31:0]   scr1_data, scr2_data, obj_data;
   logic          scr1_ok, scr2_ok, obj_ok;
   logic [SW-1:0] sdram_addr;
   logic          sdram_req;

   int checks = 0;
   int errors = 0;

   jtvigil_romarb #(
      .AW(AW), .SW(SW), .SCR1_OFFSET(O1), .SCR2_OFFSET(O2), .OBJ_OFFSET(O3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .scr1_cs    (cs[0]),
      .scr2_cs    (cs[1]),
      .obj_cs     (cs[2]),
      .scr1_addr  (a[0]),
      .scr2_addr  (a[1]),
      .obj_addr   (a[2]),
      .scr1_data  (scr1_data),
      .scr2_data  (scr2_data),
      .obj_data   (obj_data),
      .scr1_ok    (scr1_ok),
      .scr2_ok    (scr2_ok),
      .obj_ok     (obj_ok),
      .sdram_addr (sdram_addr),
      .sdram_req  (sdram_req),
      .sdram_ack  (ack),
      .sdram_rdy  (rdy),
      .sdram_dout (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: cache contents plus one open transaction
   logic [AW-1:0] m_tag [3];
   logic          m_val [3];
   logic [31:0]   m_dat [3];
   bit            m_open, m_acked, m_req;
   int            m_id, m_last;
   logic [AW-1:0] m_caddr;
   logic [SW-1:0] m_saddr;

   function automatic logic [SW-1:0] offs(input int i);
      case (i)
         0:       return O1;
         1:       return O2;
         default: return O3;
      endcase
   endfunction

   function automatic bit m_hit(input int i);
      return cs[i] && m_val[i] && (m_tag[i] == a[i]);
   endfunction

   function automatic int pick();
      int start;
`ifdef JTVIGIL_ROMARB_RR_EN
      start = (m_last + 1) % 3;
`else
      start = 0;
`endif
      for (int k = 0; k < 3; k++) begin
         int i = (start + k) % 3;
         if (cs[i] && !m_hit(i)) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_tag[i] = '0; m_val[i] = 1'b0; m_dat[i] = '0;
      end
      m_open = 0; m_acked = 0; m_req = 0; m_id = 0; m_last = 2;
      m_caddr = '0; m_saddr = '0;
   endtask

   task automatic model_fill();
      m_tag[m_id] = m_caddr;
      m_val[m_id] = 1'b1;
      m_dat[m_id] = dout;
      m_open = 0;
   endtask

   // Apply the effect of the coming rising edge under the current inputs
   task automatic model_adv();
      if (!m_open) begin
         int id = pick();
         if (id >= 0) begin
            m_open = 1; m_acked = 0; m_id = id; m_last = id;
            m_caddr = a[id];
            m_saddr = SW'(a[id]) + offs(id);
            m_req = 1;
         end
      end else if (!m_acked) begin
         if (ack) begin
            m_req = 0;
            if (rdy) model_fill();
            else m_acked = 1;
         end
      end else if (rdy) begin
         model_fill();
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string ph);
      logic        dok [3];
      logic [31:0] ddat [3];
      dok  = '{scr1_ok, scr2_ok, obj_ok};
      ddat = '{scr1_data, scr2_data, obj_data};
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s ok%0d", ph, i), 64'(dok[i]), 64'(m_hit(i)));
         chk($sformatf("%s data%0d", ph, i), 64'(ddat[i]), 64'(m_dat[i]));
      end
      chk({ph, " req"}, 64'(sdram_req), 64'(m_req));
      chk({ph, " addr"}, 64'(sdram_addr), 64'(m_saddr));
   endtask

   task automatic cyc(input string ph, input logic [2:0] ncs, input logic [AW-1:0] a0,
                      input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                      input logic nack, input logic nrdy, input logic [31:0] nd);
      @(negedge clk);
      cs = ncs; a[0] = a0; a[1] = a1; a[2] = a2;
      ack = nack; rdy = nrdy; dout = nd;
      #1;
      check_all(ph);
      model_adv();
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0;
      cs = '0; ack = 1'b0; rdy = 1'b0; dout = '0;
      #1;
      model_reset();
      check_all("rst");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      case ($urandom % 5)
         0:       return 18'h00000;
         1:       return 18'h00001;
         2:       return 18'h00002;
         3:       return 18'h00003;
         default: return 18'h3FFFF;
      endcase
   endfunction

   logic [SW-1:0] exp_ga [3];
   logic [2:0]    rcs;
   logic [AW-1:0] ra [3];

   initial begin
      rst_n = 1'b1;
      cs = '0; a[0] = '0; a[1] = '0; a[2] = '0;
      ack = 1'b0; rdy = 1'b0; dout = '0;
      model_reset();

      // Single scr2 miss then hit
      reset_dut();
      cyc("s2", 3'b010, 0, 18'h00123, 0, 0, 0, 0);
      cyc("s2", 3'b010, 0, 18'h00123, 0, 0, 0, 0);
      chk("s2 addr", 64'(sdram_addr), 64'h08123);
      chk("s2 req", 64'(sdram_req), 64'd1);
      cyc("s2", 3'b010, 0, 18'h00123, 0, 1, 0, 0);
      cyc("s2", 3'b010, 0, 18'h00123, 0, 0, 0, 0);
      cyc("s2", 3'b010, 0, 18'h00123, 0, 0, 0, 0);
      cyc("s2", 3'b010, 0, 18'h00123, 0, 0, 1, 32'hDEADBEEF);
      cyc("s2", 3'b010, 0, 18'h00123, 0, 0, 0, 0);
      chk("s2 hit ok", 64'(scr2_ok), 64'd1);
      chk("s2 hit data", 64'(scr2_data), 64'hDEADBEEF);
      repeat (3) cyc("s2", 3'b010, 0, 18'h00123, 0, 0, 0, 0);
      chk("s2 no req", 64'(sdram_req), 64'd0);

      // All three missing: scr1, scr2, obj order; ack+rdy together each time
      reset_dut();
      exp_ga = '{22'h000005, 22'h008006, 22'h3C0008};
      for (int g = 0; g < 3; g++) begin
         cyc("pri", 3'b111, 5, 6, 7, 0, 0, 0);
         cyc("pri", 3'b111, 5, 6, 7, 1, 1, 32'h12345670 + g);
         chk($sformatf("pri req%0d", g), 64'(sdram_req), 64'd1);
         chk($sformatf("pri addr%0d", g), 64'(sdram_addr), 64'(exp_ga[g]));
      end
      cyc("pri", 3'b111, 5, 6, 7, 0, 0, 0);
      chk("pri obj data", 64'(obj_data), 64'h12345672);
      chk("pri idle", 64'(sdram_req), 64'd0);

      // obj ack+rdy same cycle, FSM back in IDLE at once
      reset_dut();
      cyc("ar", 3'b100, 0, 0, 18'h00040, 0, 0, 0);
      cyc("ar", 3'b100, 0, 0, 18'h00040, 1, 1, 32'h12345678);
      cyc("ar", 3'b101, 18'h00050, 0, 18'h00040, 0, 0, 0);
      chk("ar obj data", 64'(obj_data), 64'h12345678);
      cyc("ar", 3'b101, 18'h00050, 0, 18'h00040, 0, 0, 0);
      chk("ar next req", 64'(sdram_req), 64'd1);
      chk("ar next addr", 64'(sdram_addr), 64'h000050);
      cyc("ar", 3'b101, 18'h00050, 0, 18'h00040, 1, 1, 32'h0);

      // scr1 address changes while waiting for data
      reset_dut();
      cyc("chg", 3'b001, 18'h10, 0, 0, 0, 0, 0);
      cyc("chg", 3'b001, 18'h10, 0, 0, 1, 0, 0);
      cyc("chg", 3'b001, 18'h11, 0, 0, 0, 0, 0);
      cyc("chg", 3'b001, 18'h11, 0, 0, 0, 1, 32'hA5A5A5A5);
      cyc("chg", 3'b001, 18'h11, 0, 0, 0, 0, 0);
      chk("chg ok", 64'(scr1_ok), 64'd0);
      chk("chg idle", 64'(sdram_req), 64'd0);
      chk("chg data", 64'(scr1_data), 64'hA5A5A5A5);
      cyc("chg", 3'b001, 18'h11, 0, 0, 0, 0, 0);
      chk("chg rereq", 64'(sdram_req), 64'd1);
      chk("chg readdr", 64'(sdram_addr), 64'h000011);
      cyc("chg", 3'b001, 18'h11, 0, 0, 1, 1, 32'h0);

      // Reset while waiting for data, then a late rdy
      reset_dut();
      cyc("rs", 3'b100, 0, 0, 18'h00020, 0, 0, 0);
      cyc("rs", 3'b100, 0, 0, 18'h00020, 1, 0, 0);
      reset_dut();
      cyc("rs", 3'b000, 0, 0, 18'h00020, 0, 1, 32'hCAFEF00D);
      cyc("rs", 3'b000, 0, 0, 18'h00020, 0, 0, 0);
      chk("rs req", 64'(sdram_req), 64'd0);
      chk("rs obj data", 64'(obj_data), 64'd0);
      cyc("rs", 3'b100, 0, 0, 18'h00020, 0, 0, 0);
      chk("rs obj ok", 64'(obj_ok), 64'd0);

      // Offset addition wraps modulo 2^SW
      reset_dut();
      cyc("wrap", 3'b100, 0, 0, 18'h3FFFF, 0, 0, 0);
      cyc("wrap", 3'b100, 0, 0, 18'h3FFFF, 1, 1, 32'h0BADCAFE);
      chk("wrap addr", 64'(sdram_addr), 64'h000000);
      cyc("wrap", 3'b100, 0, 0, 18'h3FFFF, 0, 0, 0);
      chk("wrap ok", 64'(obj_ok), 64'd1);

      // Random traffic with spurious rdy and occasional resets
      reset_dut();
      rcs = '0;
      for (int i = 0; i < 3; i++) ra[i] = '0;
      for (int n = 0; n < 4000; n++) begin
         for (int i = 0; i < 3; i++) begin
            if ($urandom % 8 == 0) ra[i] = rnd_addr();
            if ($urandom % 6 == 0) rcs[i] = ~rcs[i];
         end
         cyc("rnd", rcs, ra[0], ra[1], ra[2], m_req && ($urandom % 3 == 0),
             ($urandom % 3 == 0), $urandom);
         if (n % 997 == 500) reset_dut();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/jtvigil_romarb.md
JTVIGIL_ROMARB -- requirements
Module: jtvigil_romarb

Interface
REQ-001 Parameter AW, default 18, requester word-address width, identical for all three requesters.
REQ-002 Parameter SW, default 22, SDRAM word-address width.
REQ-003 Parameters SCR1_OFFSET / SCR2_OFFSET / OBJ_OFFSET, default 0 / 22'h08000 / 22'h10000, SW-bit SDRAM base per requester.
REQ-004 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 scr1_cs, scr2_cs, obj_cs  input  1 each  requester read enables.
REQ-007 scr1_addr, scr2_addr, obj_addr  input  AW each  requester word addresses.
REQ-008 scr1_data, scr2_data, obj_data  output  32 each  registered read data per requester.
REQ-009 scr1_ok, scr2_ok, obj_ok  output  1 each  data valid for the address currently presented.
REQ-010 sdram_addr  output  SW  SDRAM word address.
REQ-011 sdram_req  output  1  access request; sdram_ack  input  1  request accepted; sdram_rdy  input  1  read data valid; sdram_dout  input  32  read data.

Function
REQ-012 Each requester SHALL own one cache entry: tag (AW), valid bit, data (32).
REQ-013 x_ok SHALL be combinational: x_cs AND valid_x AND (tag_x == x_addr); hit latency 0 cycles.
REQ-014 Requester x pending = x_cs AND NOT x_ok.
REQ-015 FSM states IDLE, WAIT_ACK, WAIT_RDY.
REQ-016 IDLE: if any pending, SHALL select one (REQ-024), capture its id and address, drive sdram_addr = addr + offset (mod 2^SW), assert sdram_req next cycle, go WAIT_ACK; else stay.
REQ-017 WAIT_ACK: hold sdram_addr and sdram_req high until sdram_ack; on sdram_ack deassert sdram_req, go WAIT_RDY.
REQ-018 sdram_ack and sdram_rdy in the same cycle in WAIT_ACK SHALL be treated as ack followed by rdy in one step: data captured, go IDLE.
REQ-019 WAIT_RDY: on sdram_rdy write sdram_dout to data_x, captured address to tag_x, set valid_x, go IDLE; x_ok rises the following cycle if address unchanged.
REQ-020 Requester address change or cs drop mid-access SHALL NOT abort the access; entry is filled with the captured address and the new address re-requests from IDLE.
REQ-021 Miss latency to sdram_req: 1 cycle from pending in IDLE; back-to-back grants SHALL have one IDLE cycle between them.
REQ-022 x_data SHALL change only on a fill of entry x; other entries unaffected.
REQ-023 sdram_rdy outside WAIT_ACK/WAIT_RDY SHALL be ignored.

Reset
REQ-024 (priority, see Configuration) Fixed order scr1 > scr2 > obj when round-robin disabled.
REQ-025 rst_n low SHALL immediately force: state IDLE, sdram_req 0, sdram_addr 0, all valid 0, tags 0, data outputs 0, last-grant pointer to obj.
REQ-026 Reset mid-access SHALL discard the transaction; a late sdram_rdy after reset is ignored per REQ-023.

Configuration
REQ-027 Macro JTVIGIL_ROMARB_RR_EN defined: round-robin; search starts after last granted requester (order scr1, scr2, obj, wrap).
REQ-028 Macro undefined: fixed priority per REQ-024; last-grant pointer not implemented.

Structure
REQ-029 Shared package jtvigil_pkg SHALL hold the FSM state enum, requester id type (2-bit, SCR1=0, SCR2=1, OBJ=2) and default offsets.
REQ-030 One sub-module jtvigil_romarb_entry (tag/valid/data register plus hit compare), instantiated three times.

Verification
REQ-031 Reset, scr2_cs=1 addr=0x00123, ack after 2 cycles, rdy after 4 with 0xDEADBEEF -> sdram_addr=0x08123, scr2_data=0xDEADBEEF, scr2_ok=1; repeat same address -> no sdram_req.
REQ-032 All three cs high on misses, fixed priority -> grant order scr1, scr2, obj; with JTVIGIL_ROMARB_RR_EN and continuous misses -> grants rotate, no requester waits more than 2 other grants.
REQ-033 scr1 addr changes 0x10->0x11 during WAIT_RDY -> entry filled with tag 0x10, scr1_ok stays 0, new request for 0x11 issued after one IDLE cycle.
REQ-034 sdram_ack and sdram_rdy same cycle with 0x12345678 -> obj_data=0x12345678, FSM in IDLE next cycle.
REQ-035 rst_n pulled low in WAIT_RDY, then rdy pulses -> sdram_req 0, all ok 0, no data written.
REQ-036 obj_addr=0x3FFFF with OBJ_OFFSET=22'h3C0001 -> sdram_addr wraps to 22'h000000.
